ram_arbiter: RTL



---
 rtl/ram_arbiter_pkg.sv | 19 +
 rtl/ram_arb_fifo.sv | 56 +++++
 rtl/ram_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAM arbiter: bus widths, grant encodings and
// the full-word byte-enable constant.
package ram_arbiter_pkg;

  // Register-bus widths shared with the core and the debug module.
  localparam int REGBUS_AW = 32;
  localparam int REGBUS_DW = 32;

  // RAM byte lanes and the "write every lane" mask used by debug writes.
  localparam int                BE_W   = 4;
  localparam logic [BE_W-1:0]   BE_ALL = 4'hF;

  // Grant state: the state register value is the owner of the RAM port this cycle.
  typedef enum logic {
    GNT_CORE = 1'b0,
    GNT_DBG  = 1'b1
  } gnt_e;

endpackage

// File: rtl/ram_arb_fifo.sv
// Synchronous FIFO holding buffered debug writes ({addr, data} entries).
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ram_arb_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 64,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_push;

  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  // Entry storage: written on an accepted push.
  // NOTE: the storage array is deliberately not reset; validity is carried
  // by the pointers and count, so the array can map onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  // NOTE: all state here uses non-blocking assignment so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Merges core load/store traffic and buffered JTAG debug writes onto one
// single-port RAM. Core has priority; a starvation limit and halt_i force
// debug writes in, stalling the core for the cycle it loses the port.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int AW         = REGBUS_AW,
  parameter int DW         = REGBUS_DW,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_STARVE = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [BE_W-1:0] c_wen,
  input  logic            c_ren,
  input  logic [AW-1:0]   c_addr,
  input  logic [DW-1:0]   c_wdata,
  output logic [DW-1:0]   c_rdata,
  output logic            c_stall,
  input  logic            dbg_we,
  input  logic [AW-1:0]   dbg_addr,
  input  logic [DW-1:0]   dbg_wdata,
  input  logic            halt_i,
  output logic            dbg_ovf,
  output logic            dbg_empty,
  output logic [BE_W-1:0] m_wen,
  output logic            m_ren,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic [DW-1:0]   m_rdata
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ST_W  = (MAX_STARVE > 1) ? $clog2(MAX_STARVE) : 1;

  gnt_e             r_state;
  gnt_e             w_state_nxt;
  logic [ST_W-1:0]  r_starve;
  logic             r_rd_pend;
  logic [DW-1:0]    r_rdata_q;
  logic             r_ovf;

  logic             w_c_req;
  logic             w_pop;
  logic             w_push_ok;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_fifo_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_pending_nxt;
  logic             w_starved;
  logic [AW+DW-1:0] w_fifo_head;
  logic [AW-1:0]    w_head_addr;
  logic [DW-1:0]    w_head_data;

  assign w_c_req       = c_ren | (|c_wen);
  assign w_pop         = (r_state == GNT_DBG) & ~w_fifo_empty;
  assign w_push_ok     = dbg_we & (~w_fifo_full | w_pop);
  assign w_count_nxt   = w_fifo_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
  assign w_pending_nxt = (w_count_nxt != '0);
  assign w_starved     = (r_starve == ST_W'(MAX_STARVE - 1));
  assign w_head_addr   = w_fifo_head[AW+DW-1:DW];
  assign w_head_data   = w_fifo_head[DW-1:0];

  assign dbg_empty = w_fifo_empty;
  assign dbg_ovf   = r_ovf;
  assign c_rdata   = r_rd_pend ? m_rdata : r_rdata_q;

  ram_arb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (AW + DW)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (dbg_we),
    .i_pop   (w_pop),
    .i_wdata ({dbg_addr, dbg_wdata}),
    .o_rdata (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // Grant state register.
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= GNT_CORE;
    else       r_state <= w_state_nxt;
  end

  // Next grant: debug enters when work remains and core is idle, halted or
  // starving; it leaves after one write unless halt keeps it draining.
  // NOTE: the default assignment first keeps this block purely
  // combinational on every path, so no latch is inferred.
  always_comb begin
    w_state_nxt = GNT_CORE;
    case (r_state)
      GNT_CORE: if (w_pending_nxt && (halt_i || !w_c_req || w_starved)) w_state_nxt = GNT_DBG;
      GNT_DBG:  if (w_pending_nxt && halt_i)                            w_state_nxt = GNT_DBG;
      default:  w_state_nxt = GNT_CORE;
    endcase
  end

  // RAM port mux and core stall for the current grant.
  always_comb begin
    m_wen   = c_wen;
    m_ren   = c_ren;
    m_addr  = c_addr;
    m_wdata = c_wdata;
    c_stall = 1'b0;
    if (r_state == GNT_DBG) begin
      m_wen   = BE_ALL;
      m_ren   = 1'b0;
      m_addr  = w_head_addr;
      m_wdata = w_head_data;
      c_stall = w_c_req;
    end
  end

  // Starvation counter: counts busy core-granted cycles while debug waits.
  always_ff @(posedge clk) begin
    if (!rstn)                                   r_starve <= '0;
    else if (r_state == GNT_DBG || w_fifo_empty) r_starve <= '0;
    else if (w_c_req && !w_starved)              r_starve <= r_starve + ST_W'(1);
  end

  // Read tracking: data returns the cycle after an accepted core read and
  // is held afterwards so c_rdata stays stable between reads.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rd_pend <= 1'b0;
      r_rdata_q <= '0;
    end else begin
      r_rd_pend <= (r_state == GNT_CORE) & c_ren;
      if (r_rd_pend) r_rdata_q <= m_rdata;
    end
  end

  // Sticky overflow flag: a debug write arrived with no room for it.
  always_ff @(posedge clk) begin
    if (!rstn)                   r_ovf <= 1'b0;
    else if (dbg_we && !w_push_ok) r_ovf <= 1'b1;
  end

endmodule
